// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared definitions for the hardwired control sequencer.
//   state_t    - sequencer states (IDLE, fetch/execute T-states, HALTED), 4-bit
//   op_class_t - execution class of an instruction opcode
//   OP_*       - ALU/instruction opcodes as carried in IR[31:27]
//   IR_*       - bit positions of the instruction register fields
package ctrl_pkg;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_T0     = 4'd1,
        ST_T1     = 4'd2,
        ST_T2     = 4'd3,
        ST_T3     = 4'd4,
        ST_T4     = 4'd5,
        ST_T5     = 4'd6,
        ST_T6     = 4'd7,
        ST_HALTED = 4'd8
    } state_t;

    typedef enum logic [2:0] {
        CLS_BINARY,
        CLS_MULDIV,
        CLS_UNARY,
        CLS_HALT,
        CLS_ILLEGAL
    } op_class_t;

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_SHR  = 5'b00101;
    localparam logic [4:0] OP_SHRA = 5'b00110;
    localparam logic [4:0] OP_SHL  = 5'b00111;
    localparam logic [4:0] OP_ROR  = 5'b01000;
    localparam logic [4:0] OP_ROL  = 5'b01001;
    localparam logic [4:0] OP_AND  = 5'b01010;
    localparam logic [4:0] OP_OR   = 5'b01011;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    localparam int unsigned REG_IDX_W = 4;

    localparam int unsigned IR_OP_HI = 31;
    localparam int unsigned IR_OP_LO = 27;
    localparam int unsigned IR_RA_HI = 26;
    localparam int unsigned IR_RA_LO = 23;
    localparam int unsigned IR_RB_HI = 22;
    localparam int unsigned IR_RB_LO = 19;
    localparam int unsigned IR_RC_HI = 18;
    localparam int unsigned IR_RC_LO = 15;

    function automatic op_class_t classify(input logic [4:0] op);
        op_class_t cls;
        case (op)
            OP_ADD, OP_SUB, OP_SHR, OP_SHRA, OP_SHL,
            OP_ROR, OP_ROL, OP_AND, OP_OR:   cls = CLS_BINARY;
            OP_MUL, OP_DIV:                  cls = CLS_MULDIV;
            OP_NEG, OP_NOT:                  cls = CLS_UNARY;
            OP_HALT:                         cls = CLS_HALT;
            default:                         cls = CLS_ILLEGAL;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/reg_select_decoder.sv
// reg_select_decoder: register index to one-hot select.
//   idx    - register number
//   en     - when 0 the output is all zero
//   onehot - bit idx set when enabled; indices >= NREGS select nothing
module reg_select_decoder
    import ctrl_pkg::*;
#(
    parameter int unsigned NREGS = 16
) (
    input  logic [REG_IDX_W-1:0] idx,
    input  logic                 en,
    output logic [NREGS-1:0]     onehot
);

    assign onehot = en ? ({{(NREGS-1){1'b0}}, 1'b1} << idx) : '0;

endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: hardwired fetch/decode/execute control for the datapath.
//   Clock  - system clock, rising edge
//   clear  - asynchronous active-high reset
//   Run    - 1 = keep executing, 0 = stop at the next instruction boundary
//   IR     - instruction register fed back from the datapath
//   Rin/Rout - one-hot general register load / bus-drive enables
//   PCout..HIin - single-bit datapath strobes
//   opcode - ALU operation select (holds last driven value)
//   Halted - sticky halt indication, Illegal - one-cycle bad-opcode pulse
//   state  - current sequencer state for debug
module control_sequencer
    import ctrl_pkg::*;
#(
    parameter int unsigned NREGS = 16
) (
    input  logic             Clock,
    input  logic             clear,
    input  logic             Run,
    input  logic [31:0]      IR,
    output logic [NREGS-1:0] Rin,
    output logic [NREGS-1:0] Rout,
    output logic             PCout,
    output logic             PCin,
    output logic             IncPC,
    output logic             MARin,
    output logic             MDRin,
    output logic             MDRout,
    output logic             Read,
    output logic             IRin,
    output logic             Yin,
    output logic             Zin,
    output logic             Zlowout,
    output logic             Zhighout,
    output logic             LOin,
    output logic             HIin,
    output logic [4:0]       opcode,
    output logic             Halted,
    output logic             Illegal,
    output logic [3:0]       state
);

    state_t                 state_q;
    state_t                 state_d;
    logic [4:0]             opcode_q;
    logic [4:0]             op;
    logic [REG_IDX_W-1:0]   ra;
    logic [REG_IDX_W-1:0]   rb;
    logic [REG_IDX_W-1:0]   rc;
    op_class_t              cls;
    logic                   instr_end;
    logic                   drive_op;
    logic                   rin_en;
    logic                   rout_en;
    logic [REG_IDX_W-1:0]   rout_idx;
    logic                   unused_ir_bits;

    assign op  = IR[IR_OP_HI:IR_OP_LO];
    assign ra  = IR[IR_RA_HI:IR_RA_LO];
    assign rb  = IR[IR_RB_HI:IR_RB_LO];
    assign rc  = IR[IR_RC_HI:IR_RC_LO];
    assign cls = classify(op);
    assign unused_ir_bits = ^IR[14:0];

    // Last T-state of each instruction class; Run is only looked at here and in IDLE.
    always_comb begin
        instr_end = 1'b0;
        case (state_q)
            ST_T3:   instr_end = (cls == CLS_ILLEGAL);
            ST_T4:   instr_end = (cls == CLS_UNARY);
            ST_T5:   instr_end = (cls == CLS_BINARY);
            ST_T6:   instr_end = 1'b1;
            default: instr_end = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   state_d = Run ? ST_T0 : ST_IDLE;
            ST_T0:     state_d = ST_T1;
            ST_T1:     state_d = ST_T2;
            ST_T2:     state_d = ST_T3;
            ST_T3:     state_d = (cls == CLS_HALT) ? ST_HALTED : ST_T4;
            ST_T4:     state_d = ST_T5;
            ST_T5:     state_d = ST_T6;
            ST_T6:     state_d = ST_IDLE;
            ST_HALTED: state_d = ST_HALTED;
            default:   state_d = ST_IDLE;
        endcase
        if (instr_end) begin
            state_d = Run ? ST_T0 : ST_IDLE;
        end
    end

    always_ff @(posedge Clock or posedge clear) begin
        if (clear) begin
            state_q  <= ST_IDLE;
            opcode_q <= '0;
        end else begin
            state_q <= state_d;
            if (drive_op) begin
                opcode_q <= op;
            end
        end
    end

    // Strobes decode from the registered state and IR only, so they are
    // stable for the full cycle and drop as soon as clear resets state_q.
    always_comb begin
        PCout    = 1'b0;
        PCin     = 1'b0;
        IncPC    = 1'b0;
        MARin    = 1'b0;
        MDRin    = 1'b0;
        MDRout   = 1'b0;
        Read     = 1'b0;
        IRin     = 1'b0;
        Yin      = 1'b0;
        Zin      = 1'b0;
        Zlowout  = 1'b0;
        Zhighout = 1'b0;
        LOin     = 1'b0;
        HIin     = 1'b0;
        Illegal  = 1'b0;
        drive_op = 1'b0;
        rin_en   = 1'b0;
        rout_en  = 1'b0;
        rout_idx = rb;
        case (state_q)
            ST_T0: begin
                PCout = 1'b1;
                MARin = 1'b1;
                IncPC = 1'b1;
                Zin   = 1'b1;
            end
            ST_T1: begin
                Zlowout = 1'b1;
                PCin    = 1'b1;
                Read    = 1'b1;
                MDRin   = 1'b1;
            end
            ST_T2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            ST_T3: begin
                case (cls)
                    CLS_BINARY, CLS_MULDIV: begin
                        rout_en = 1'b1;
                        Yin     = 1'b1;
                    end
                    CLS_UNARY: begin
                        rout_en  = 1'b1;
                        drive_op = 1'b1;
                        Zin      = 1'b1;
                    end
                    CLS_ILLEGAL: Illegal = 1'b1;
                    default: ;
                endcase
            end
            ST_T4: begin
                case (cls)
                    CLS_BINARY, CLS_MULDIV: begin
                        rout_en  = 1'b1;
                        rout_idx = rc;
                        drive_op = 1'b1;
                        Zin      = 1'b1;
                    end
                    CLS_UNARY: begin
                        Zlowout = 1'b1;
                        rin_en  = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_T5: begin
                case (cls)
                    CLS_BINARY: begin
                        Zlowout = 1'b1;
                        rin_en  = 1'b1;
                    end
                    CLS_MULDIV: begin
                        Zlowout = 1'b1;
                        LOin    = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_T6: begin
                if (cls == CLS_MULDIV) begin
                    Zhighout = 1'b1;
                    HIin     = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign opcode = drive_op ? op : opcode_q;
    assign Halted = (state_q == ST_HALTED);
    assign state  = state_q;

    reg_select_decoder #(.NREGS(NREGS)) u_rin_dec (
        .idx    (ra),
        .en     (rin_en),
        .onehot (Rin)
    );

    reg_select_decoder #(.NREGS(NREGS)) u_rout_dec (
        .idx    (rout_idx),
        .en     (rout_en),
        .onehot (Rout)
    );

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: drives control_sequencer against a behavioural datapath
// (register file, PC/MAR/MDR/Y/Z/LO/HI, instruction memory) and checks
// per-cycle strobes plus architectural results against an instruction-level model.
module tb_control_sequencer;
    import ctrl_pkg::*;

    logic        Clock = 1'b0;
    logic        clear;
    logic        Run;
    logic [31:0] IR;
    logic [15:0] Rin, Rout;
    logic        PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, IRin;
    logic        Yin, Zin, Zlowout, Zhighout, LOin, HIin;
    logic [4:0]  opcode;
    logic        Halted, Illegal;
    logic [3:0]  state;

    always #5 Clock = ~Clock;

    control_sequencer #(.NREGS(16)) dut (
        .Clock(Clock), .clear(clear), .Run(Run), .IR(IR),
        .Rin(Rin), .Rout(Rout),
        .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin),
        .MDRin(MDRin), .MDRout(MDRout), .Read(Read), .IRin(IRin),
        .Yin(Yin), .Zin(Zin), .Zlowout(Zlowout), .Zhighout(Zhighout),
        .LOin(LOin), .HIin(HIin), .opcode(opcode),
        .Halted(Halted), .Illegal(Illegal), .state(state)
    );

    // ---------------- behavioural datapath ----------------
    logic [31:0] R [16];
    logic [31:0] PC, MAR, MDR, Y, LO, HI, bus;
    logic [63:0] Z;
    logic [31:0] mem [256];
    logic        pre_en;
    logic [3:0]  pre_idx;
    logic [31:0] pre_val;

    function automatic logic [63:0] alu_ref(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [4:0]  s;
        logic [31:0] t;
        s = b[4:0];
        t = '0;
        case (op)
            5'b00011: t = a + b;
            5'b00100: t = a - b;
            5'b00101: t = a >> s;
            5'b00110: t = $signed(a) >>> s;
            5'b00111: t = a << s;
            5'b01000: t = (a >> s) | (a << (6'd32 - {1'b0, s}));
            5'b01001: t = (a << s) | (a >> (6'd32 - {1'b0, s}));
            5'b01010: t = a & b;
            5'b01011: t = a | b;
            5'b01111: return {32'd0, a} * {32'd0, b};
            5'b10000: return (b == 32'd0) ? 64'd0 : {a % b, a / b};
            5'b10001: t = 32'd0 - b;
            5'b10010: t = ~b;
            default:  t = '0;
        endcase
        return {32'd0, t};
    endfunction

    always_comb begin
        bus = '0;
        if (PCout)    bus = PC;
        if (Zlowout)  bus = Z[31:0];
        if (Zhighout) bus = Z[63:32];
        if (MDRout)   bus = MDR;
        for (int n = 0; n < 16; n++) if (Rout[n]) bus = R[n];
    end

    always @(posedge Clock or posedge clear) begin
        if (clear) begin
            PC <= '0;
            IR <= '0;
        end else begin
            if (MARin) MAR <= bus;
            if (Zin)   Z   <= IncPC ? {32'd0, PC + 32'd1} : alu_ref(opcode, Y, bus);
            if (PCin)  PC  <= bus;
            if (MDRin) MDR <= Read ? mem[MAR[7:0]] : bus;
            if (IRin)  IR  <= bus;
            if (Yin)   Y   <= bus;
            if (LOin)  LO  <= bus;
            if (HIin)  HI  <= bus;
            for (int n = 0; n < 16; n++) if (Rin[n]) R[n] <= bus;
            if (pre_en) R[pre_idx] <= pre_val;
        end
    end

    // ---------------- instruction-level model and checking ----------------
    typedef struct packed {
        logic [15:0] s;     // {Halted,Illegal,HIin,LOin,Zhi,Zlo,Zin,Yin,IRin,Read,MDRout,MDRin,MARin,IncPC,PCin,PCout}
        logic [15:0] rin;
        logic [15:0] rout;
    } strb_t;

    localparam int S_PCOUT = 0, S_PCIN = 1, S_INCPC = 2, S_MARIN = 3, S_MDRIN = 4;
    localparam int S_MDROUT = 5, S_READ = 6, S_IRIN = 7, S_YIN = 8, S_ZIN = 9;
    localparam int S_ZLO = 10, S_ZHI = 11, S_LOIN = 12, S_HIIN = 13, S_ILL = 14, S_HALT = 15;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] arch_R [16];
    logic [31:0] arch_lo, arch_hi;
    logic [7:0]  pc_arch;
    logic [4:0]  last_op;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic strb_t sample();
        strb_t v;
        v.s    = {Halted, Illegal, HIin, LOin, Zhighout, Zlowout, Zin, Yin,
                  IRin, Read, MDRout, MDRin, MARin, IncPC, PCin, PCout};
        v.rin  = Rin;
        v.rout = Rout;
        return v;
    endfunction

    // 0 binary, 1 mul/div, 2 unary, 3 halt, 4 illegal
    function automatic int cls_of(input logic [4:0] op);
        if (op >= 5'd3 && op <= 5'd11) return 0;
        if (op == 5'd15 || op == 5'd16) return 1;
        if (op == 5'd17 || op == 5'd18) return 2;
        if (op == 5'd27) return 3;
        return 4;
    endfunction

    function automatic int ncyc(input int c);
        case (c)
            0: return 6;
            1: return 7;
            2: return 5;
            default: return 4;
        endcase
    endfunction

    function automatic strb_t exp_cycle(input logic [31:0] instr, input int k, output bit drv);
        strb_t e;
        int c;
        logic [3:0] ra, rb, rc;
        e = '0;
        drv = 1'b0;
        c = cls_of(instr[31:27]);
        ra = instr[26:23];
        rb = instr[22:19];
        rc = instr[18:15];
        case (k)
            0: begin e.s[S_PCOUT] = 1; e.s[S_MARIN] = 1; e.s[S_INCPC] = 1; e.s[S_ZIN] = 1; end
            1: begin e.s[S_ZLO] = 1; e.s[S_PCIN] = 1; e.s[S_READ] = 1; e.s[S_MDRIN] = 1; end
            2: begin e.s[S_MDROUT] = 1; e.s[S_IRIN] = 1; end
            3: begin
                if (c <= 1) begin e.rout[rb] = 1; e.s[S_YIN] = 1; end
                else if (c == 2) begin e.rout[rb] = 1; e.s[S_ZIN] = 1; drv = 1'b1; end
                else if (c == 4) e.s[S_ILL] = 1;
            end
            4: begin
                if (c <= 1) begin e.rout[rc] = 1; e.s[S_ZIN] = 1; drv = 1'b1; end
                else if (c == 2) begin e.s[S_ZLO] = 1; e.rin[ra] = 1; end
            end
            5: begin
                if (c == 0) begin e.s[S_ZLO] = 1; e.rin[ra] = 1; end
                else if (c == 1) begin e.s[S_ZLO] = 1; e.s[S_LOIN] = 1; end
            end
            6: if (c == 1) begin e.s[S_ZHI] = 1; e.s[S_HIIN] = 1; end
            default: ;
        endcase
        return e;
    endfunction

    task automatic preload(input logic [3:0] idx, input logic [31:0] val);
        pre_en = 1'b1;
        pre_idx = idx;
        pre_val = val;
        arch_R[idx] = val;
        @(negedge Clock);
        pre_en = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, " idle strobes"}, sample(), '0);
        chk({tag, " idle state"}, state, ST_IDLE);
        chk({tag, " idle opcode"}, opcode, last_op);
    endtask

    // Called at a negedge with the sequencer in IDLE; returns at the T0 negedge.
    task automatic go();
        check_idle("go");
        Run = 1'b1;
        @(negedge Clock);
    endtask

    // Called at the negedge of T0; returns at the negedge after the instruction end.
    task automatic exec(input logic [31:0] instr, input bit run_after, input int run_mid, input int abort_at);
        strb_t e;
        bit drv;
        int c, n;
        logic [4:0] op;
        logic [3:0] ra, rb, rc;
        logic [63:0] r64;
        state_t ts [7];
        ts = '{ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6};
        op = instr[31:27];
        ra = instr[26:23];
        rb = instr[22:19];
        rc = instr[18:15];
        c = cls_of(op);
        n = ncyc(c);
        mem[pc_arch] = instr;
        for (int k = 0; k < n; k++) begin
            e = exp_cycle(instr, k, drv);
            chk($sformatf("strobes ir=%h T%0d", instr, k), sample(), e);
            chk($sformatf("state ir=%h T%0d", instr, k), state, ts[k]);
            chk($sformatf("opcode ir=%h T%0d", instr, k), opcode, drv ? op : last_op);
            if (drv) last_op = op;
            if (k == abort_at) begin
                #2 clear = 1'b1;
                #1;
                chk("clear strobes", sample(), '0);
                chk("clear state", state, ST_IDLE);
                chk("clear opcode", opcode, 64'd0);
                @(negedge Clock);
                clear = 1'b0;
                Run = 1'b0;
                pc_arch = '0;
                last_op = '0;
                return;
            end
            if (k < n - 1) Run = (run_mid < 0) ? 1'($urandom_range(0, 1)) : 1'(run_mid);
            else Run = run_after;
            @(negedge Clock);
        end
        pc_arch = pc_arch + 8'd1;
        case (c)
            0: begin r64 = alu_ref(op, arch_R[rb], arch_R[rc]); arch_R[ra] = r64[31:0]; end
            1: begin r64 = alu_ref(op, arch_R[rb], arch_R[rc]); arch_lo = r64[31:0]; arch_hi = r64[63:32]; end
            2: begin r64 = alu_ref(op, 32'd0, arch_R[rb]); arch_R[ra] = r64[31:0]; end
            default: ;
        endcase
        if (c == 1) begin
            chk($sformatf("LO ir=%h", instr), LO, arch_lo);
            chk($sformatf("HI ir=%h", instr), HI, arch_hi);
        end else if (c != 3) begin
            chk($sformatf("Ra ir=%h", instr), R[ra], arch_R[ra]);
        end
    endtask

    typedef struct {
        logic [31:0] instr;
        logic [31:0] ra_init;
        logic [31:0] rb_val;
        logic [31:0] rc_val;
        bit          md;
        logic [31:0] exp_lo;
        logic [31:0] exp_hi;
        int          run_mid;
    } vec_t;

    vec_t        vt [10];
    logic [31:0] w;
    logic [4:0]  rop;
    bit          at_t0;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{32'h18918000, 32'h0,      32'h8,        32'h2,        1'b0, 32'd10,       32'd0, 1}; // add
        vt[1] = '{32'h30918000, 32'h0,      32'h80000008, 32'h2,        1'b0, 32'hE0000002, 32'd0, 1}; // shra
        vt[2] = '{32'h78918000, 32'h5555,   32'd6,        32'd7,        1'b1, 32'd42,       32'd0, 1}; // mul
        vt[3] = '{32'h8AA00000, 32'h0,      32'd5,        32'h0,        1'b0, 32'hFFFFFFFB, 32'd0, 1}; // neg
        vt[4] = '{32'h20918000, 32'h0,      32'd8,        32'd2,        1'b0, 32'd6,        32'd0, 1}; // sub
        vt[5] = '{32'h80918000, 32'h7777,   32'd45,       32'd7,        1'b1, 32'd6,        32'd3, 1}; // div
        vt[6] = '{32'h92A00000, 32'h0,      32'h0F0F0F0F, 32'h0,        1'b0, 32'hF0F0F0F0, 32'd0, 1}; // not
        vt[7] = '{32'hF8918000, 32'hABCD,   32'd1,        32'd2,        1'b0, 32'hABCD,     32'd0, 1}; // illegal
        vt[8] = '{32'h18898000, 32'h0,      32'd5,        32'd4,        1'b0, 32'd9,        32'd0, 1}; // add R1,R1,R3
        vt[9] = '{32'h18918000, 32'h0,      32'd100,      32'd23,       1'b0, 32'd123,      32'd0, 0}; // Run low mid-instr

        pc_arch = '0;
        last_op = '0;
        pre_en  = 1'b0;
        pre_idx = '0;
        pre_val = '0;
        Run     = 1'b1;
        clear   = 1'b1;
        @(negedge Clock);
        check_idle("reset");
        @(negedge Clock);
        check_idle("reset run");
        Run = 1'b0;
        clear = 1'b0;
        @(negedge Clock);
        check_idle("post reset");
        @(negedge Clock);
        check_idle("run low");

        for (int i = 0; i < 10; i++) begin
            w = vt[i].instr;
            preload(w[26:23], vt[i].ra_init);
            preload(w[22:19], vt[i].rb_val);
            preload(w[18:15], vt[i].rc_val);
            go();
            exec(w, 1'b0, vt[i].run_mid, -1);
            if (vt[i].md) begin
                chk($sformatf("vec%0d LO", i), LO, vt[i].exp_lo);
                chk($sformatf("vec%0d HI", i), HI, vt[i].exp_hi);
                chk($sformatf("vec%0d Ra untouched", i), R[w[26:23]], vt[i].ra_init);
            end else begin
                chk($sformatf("vec%0d Ra", i), R[w[26:23]], vt[i].exp_lo);
            end
        end

        // clear in T4 of an add: destination must keep its old value
        preload(4'd1, 32'h1234);
        preload(4'd2, 32'd8);
        preload(4'd3, 32'd2);
        go();
        exec(32'h18918000, 1'b1, 1, 4);
        check_idle("after clear");
        @(negedge Clock);
        check_idle("after clear 2");
        chk("clear R1 kept", R[1], 32'h1234);

        // random instruction stream against the instruction-level model
        for (int i = 0; i < 16; i++) preload(4'(i), $urandom);
        at_t0 = 1'b0;
        for (int t = 0; t < 150; t++) begin
            if ($urandom_range(0, 9) == 0) begin
                do rop = 5'($urandom_range(0, 31)); while (cls_of(rop) != 4);
            end else begin
                do rop = 5'($urandom_range(0, 31)); while (cls_of(rop) > 2);
            end
            w = $urandom;
            w[31:27] = rop;
            if (!at_t0) begin
                repeat ($urandom_range(0, 2)) begin
                    check_idle("rand wait");
                    @(negedge Clock);
                end
                go();
            end
            at_t0 = ($urandom_range(0, 3) != 0);
            exec(w, at_t0, -1, -1);
        end

        // halt holds with Run high until clear
        if (!at_t0) go();
        exec(32'hD8000000, 1'b1, 1, -1);
        for (int i = 0; i < 5; i++) begin
            chk("halted strobes", sample(), 64'(48'h8000_0000_0000));
            chk("halted state", state, ST_HALTED);
            chk("halted opcode", opcode, last_op);
            @(negedge Clock);
        end
        #2 clear = 1'b1;
        #1;
        chk("halt clear strobes", sample(), '0);
        chk("halt clear state", state, ST_IDLE);
        chk("halt clear opcode", opcode, 64'd0);
        Run = 1'b0;
        @(negedge Clock);
        clear = 1'b0;
        last_op = '0;
        @(negedge Clock);
        check_idle("final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
# control_sequencer

Hardwired control unit that drives the `datapath` strobes through fetch/decode/execute T-states for register-register ALU instructions. It replaces hand-sequenced stimulus. It reads the instruction register and produces every register-in/out enable, memory strobe and ALU opcode cycle by cycle. It sits beside `datapath` in the CPU top level, with IR fed back from the datapath.

## Interface
- Parameters
- `NREGS`, 16: general registers R0..R(NREGS-1); the register fields are 4 bits wide.
- Ports
- `Clock`  in  1  system clock; all state changes on rising edge
- `clear`  in  1  reset, asynchronous, active-high
- `Run`  in  1  level; 1 = fetch and execute, 0 = stop at next instruction boundary
- `IR`  in  32  instruction register contents from datapath
- `Rin`  out  NREGS  one-hot general-register load enables (bit n = Rnin)
- `Rout`  out  NREGS  one-hot general-register bus drives (bit n = Rnout)
- `PCout`, `PCin`, `IncPC`, `MARin`, `MDRin`, `MDRout`, `Read`, `IRin`, `Yin`, `Zin`, `Zlowout`, `Zhighout`, `LOin`, `HIin`  out  1 each  datapath strobes
- `opcode`  out  5  ALU operation select
- `Halted`  out  1  sticky; halt instruction executed
- `Illegal`  out  1  one-cycle pulse; undecodable opcode
- `state`  out  4  current state (debug)

## Operation
- IR fields: [31:27] op, [26:23] Ra (destination), [22:19] Rb, [18:15] Rc.
- States: IDLE, T0..T6, HALTED.
- IDLE
  - All strobes 0.
  - Run=1 → T0.
- Fetch, common to all instructions:
  - T0: PCout, MARin, IncPC, Zin.
  - T1: Zlowout, PCin, Read, MDRin.
  - T2: MDRout, IRin.
- Binary ops (add 00011, sub 00100, shr 00101, shra 00110, shl 00111, ror 01000, rol 01001, and 01010, or 01011):
  - T3: Rout[Rb], Yin.
  - T4: Rout[Rc], opcode=op, Zin.
  - T5: Zlowout, Rin[Ra]. Instruction ends.
- mul 01111, div 10000:
  - T3 and T4 as for binary ops.
  - T5: Zlowout, LOin.
  - T6: Zhighout, HIin. Instruction ends.
- Unary ops (neg 10001, not 10010):
  - T3: Rout[Rb], opcode=op, Zin.
  - T4: Zlowout, Rin[Ra]. Instruction ends.
- halt 11011:
  - T3 → HALTED.
  - Halted=1 from HALTED entry until clear; all strobes 0 in HALTED.
- Any other op:
  - T3 asserts Illegal for one cycle, no register write.
  - The T3 cycle counts as the instruction end.
- At instruction end: Run=1 → T0, else → IDLE.
- Run is sampled only in IDLE and at instruction end. Deasserting Run mid-instruction never truncates it.
- `opcode` holds its last driven value outside T3/T4. It is forced to 0 only by reset.
- At most one bit of Rin and at most one bit of Rout is set in any cycle. They are never both set for the same register index.

## Timing
- Strobe generation:
  - Strobes are Moore outputs decoded from the registered state plus IR.
  - They are stable for the whole cycle; the datapath captures on the closing rising edge.
- Latency, counted from the T0 cycle: binary 6 cycles, mul/div 7, unary 5, illegal 4, halt 4 cycles to HALTED.
- IR is updated at the end of T2, so decode uses IR from T3 onward. IR contents in T0–T2 are ignored.
- `Read` is high in T1 only. Memory data must be valid within T1 (single-cycle memory).
- `clear`, including mid-instruction:
  - Immediately forces IDLE, Halted=0, Illegal=0, opcode=0, every strobe/Rin/Rout=0, state=IDLE.
  - No partial register write survives.
- Ra=Rb or Ra=Rc is legal: the read occurs in T3/T4 and the write in T5.

## Structure
- `ctrl_pkg`: state enum (4-bit encoding), opcode localparams, IR field bit positions.
- Sub-module `reg_select_decoder`:
  - 4-bit index plus enable → NREGS one-hot.
  - Instantiated twice, once for Rin and once for Rout.
- Top level contains the state register, next-state logic and output decode only.

## Test plan
- add, IR=0x18918000 (Ra=1, Rb=2, Rc=3):
  - R2=8, R3=2 → R1=10.
  - Rout[2] in T3, Rout[3] with opcode=00011 in T4, Rin[1] in T5.
  - 6 cycles; back-to-back T0 with Run=1.
- shra R1,R2,R3 with R2=0x80000008, R3=2 → R1=0xE0000002; opcode=00110 in T4 only.
- mul R2=6, R3=7 → LO=42, HI=0; LOin in T5, HIin in T6; Rin stays all-zero throughout.
- neg with Rb=R4=5 → Ra=0xFFFFFFFB in 5 cycles. Illegal op 11111 → Illegal pulse in T3, no Rin bit set.
- halt → Halted=1 and state=HALTED, holding indefinitely with Run=1.
- Run=0 during T4 completes the add and then goes to IDLE. `clear` during T4 drops all outputs asynchronously; the destination register is unchanged.
